picorv32_mem_arbiter: RTL and testbench
=======================================

# picorv32_mem_arbiter

Two-master arbiter that shares one picorv32-native memory port (valid/ready, addr/wdata/wstrb/rdata) between two requesters, e.g. a core and a loader/DMA, or two cores on one simulation memory. It sits between the masters and the single-port word memory. It provides round-robin grant, a response timeout with error capture, and full request/response pass-through.

## Interface
Parameters:
- TIMEOUT, 16: BUSY cycles without slave response before the arbiter terminates the access itself; legal range ≥ 2.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on a timed-out access.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- m0_valid, m1_valid  in  1  master request.
- m0_instr, m1_instr  in  1  instruction-fetch tag.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_wstrb, m1_wstrb  in  4  byte strobes; 0 means read.
- m0_ready, m1_ready  out  1  response strobe to master.
- m0_rdata, m1_rdata  out  32  read data to master.
- s_valid  out  1  request to memory.
- s_instr  out  1  forwarded instr tag.
- s_addr  out  32  forwarded address.
- s_wdata  out  32  forwarded write data.
- s_wstrb  out  4  forwarded strobes.
- s_ready  in  1  memory response strobe.
- s_rdata  in  32  memory read data.
- grant  out  2  one-hot current owner; 0 when idle.
- err  out  1  sticky timeout flag.
- err_addr  out  32  address of the first timed-out access.
- err_master  out  1  master index of the first timed-out access.
- err_clr  in  1  clears err, err_addr and err_master.

## Operation
- States: IDLE, BUSY. Registers: owner (1 bit), rr_last (1 bit), cnt, err, err_addr, err_master.
- IDLE: if any mX_valid is set, grant goes to that master. If both are set, grant goes to the master ≠ rr_last. On the edge, enter BUSY with owner latched and cnt=0.
- BUSY: s_valid/s_instr/s_addr/s_wdata/s_wstrb = owner's inputs; cnt increments each cycle.
  - s_ready=1: owner's mX_ready=1 and mX_rdata=s_rdata, combinational. On the edge: rr_last=owner, go to IDLE.
  - s_ready=0 and cnt==TIMEOUT-1 (timeout cycle): s_valid forced 0; owner's mX_ready=1, mX_rdata=ERR_RDATA. On the edge: if err=0, set err=1 and capture err_addr/err_master; rr_last=owner; go to IDLE. If err is already 1, the captured values are kept and only the first error is recorded.
  - Owner's valid drops without ready (protocol violation): go to IDLE on the edge, no response, no error, rr_last unchanged.
- s_ready wins over timeout in the same cycle.
- The non-owner's ready is 0 and its rdata is 0 in every state.
- IDLE: all s_* outputs are 0.
- err_clr is applied at the edge. A timeout capture at the same edge takes priority over err_clr.
- cnt width is $clog2(TIMEOUT).

## Timing
- Reset value of every output is 0, err included. After reset: state=IDLE, rr_last=1, so m0 wins the first tie.
- Arbitration latency is one cycle: a request in cycle t drives s_valid in cycle t+1.
- Slave response in cycle t+1+k gives mX_ready in the same cycle (zero-cycle response path). The arbiter is IDLE in cycle t+2+k.
- Minimum access spacing per master is 3 cycles with a 1-cycle-latency memory.
- The arbiter never re-presents a served request. The master lowers valid on the edge where it samples ready, and the arbiter is IDLE after that same edge.
- Worst-case hold: a timeout response in the TIMEOUT-th BUSY cycle, with s_valid high for TIMEOUT-1 cycles before it.
- Reset mid-BUSY: on the next edge state=IDLE and all outputs are 0. The in-flight access gets no response.

## Structure
- Shared package picorv32_mem_pkg holds:
  - typedef mem_req_t {valid, instr, addr, wdata, wstrb};
  - typedef mem_rsp_t {ready, rdata};
  - state enum {IDLE, BUSY};
  - localparam DEFAULT_ERR_RDATA.
- One natural sub-module, rr_arb2: a 2-way round-robin picker, combinational, with inputs req[1:0] and last and output gnt one-hot. The FSM, the timeout counter and the muxes stay in the top module.

## Test plan
1. m0 read of 0x10 against a 1-cycle memory holding 0x1234_5678 -> s_valid in cycle 1, m0_ready in cycle 2 with rdata 0x1234_5678, grant=01 in cycles 1-2, m1_ready=0 throughout.
2. m0 and m1 both continuously valid after reset -> grants alternate m0, m1, m0, m1, and each master is served once every 6 cycles.
3. Only m1 is requesting, back-to-back -> m1 is served every 3 cycles and rr_last does not block it.
4. TIMEOUT=16, memory never ready, m0 at 0x400 -> m0_ready in the 16th BUSY cycle with 0xDEAD_BEEF, then err=1, err_addr=0x400, err_master=0. A second timeout leaves the capture unchanged. err_clr zeroes all three.
5. m1 write of 0xA5A5_0F0F to 0x20 with wstrb 4'b0101 -> s_addr/s_wdata/s_wstrb match exactly, m1_ready when s_ready, m0_rdata=0.
6. reset asserted in cycle 2 of BUSY -> in the next cycle grant=0, s_valid=0, err=0, and a fresh m1 request is served normally.

Source files
------------

// File: rtl/picorv32_mem_pkg.sv
// -----------------------------------------------------------------------------
// picorv32_mem_pkg
// Shared types for the picorv32-native memory port (valid/ready handshake with
// addr/wdata/wstrb/rdata). The arbiter uses them for its request and response
// bundles and for its FSM state.
// -----------------------------------------------------------------------------
package picorv32_mem_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // One master-side request, as seen on the native port.
   typedef struct packed {
      logic        valid;
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;   // 0 means read
   } mem_req_t;

   // One response, as returned to a master.
   typedef struct packed {
      logic        ready;
      logic [31:0] rdata;
   } mem_rsp_t;

   // Read data returned to a master whose access was terminated by timeout.
   localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/picorv32_mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin picker, purely combinational.
//   req  [1:0] in   request vector, bit i = master i
//   last       in   index of the master served most recently
//   gnt  [1:0] out  one-hot pick, 0 when nothing is requested
// On a tie the master that was NOT served last wins.
// -----------------------------------------------------------------------------
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path through the case can leave it unassigned and infer a latch.
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// picorv32_mem_arbiter
// Shares one picorv32-native memory port between two masters with round-robin
// grant and a response timeout that terminates a stuck access and records it.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   mX_valid/instr/addr/wdata/wstrb master X request (X = 0, 1)
//   mX_ready, mX_rdata             master X response (only the owner's is live)
//   s_valid/instr/addr/wdata/wstrb request forwarded to memory
//   s_ready, s_rdata               memory response
//   grant                          one-hot current owner, 0 when idle
//   err, err_addr, err_master      sticky record of the first timed-out access
//   err_clr                        clears the error record at the edge
// -----------------------------------------------------------------------------
module picorv32_mem_arbiter
   import picorv32_mem_pkg::*;
#(
   parameter int          TIMEOUT   = 16,
   parameter logic [31:0] ERR_RDATA = DEFAULT_ERR_RDATA
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,

   input  logic        m1_valid,
   input  logic        m1_instr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,

   output logic        s_valid,
   output logic        s_instr,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic        s_ready,
   input  logic [31:0] s_rdata,

   output logic [1:0]  grant,
   output logic        err,
   output logic [31:0] err_addr,
   output logic        err_master,
   input  logic        err_clr
);

   localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state, state_nxt;
   logic             owner, owner_nxt;
   logic             rr_last, rr_last_nxt;
   logic [CNT_W-1:0] cnt;
   logic             timed_out;
   logic [1:0]       pick;

   mem_req_t req0, req1, own_req, s_req;
   mem_rsp_t rsp;

   assign req0 = '{valid: m0_valid, instr: m0_instr, addr: m0_addr,
                   wdata: m0_wdata, wstrb: m0_wstrb};
   assign req1 = '{valid: m1_valid, instr: m1_instr, addr: m1_addr,
                   wdata: m1_wdata, wstrb: m1_wstrb};
   assign own_req = owner ? req1 : req0;

   rr_arb2 u_rr_arb2 (
      .req  ({m1_valid, m0_valid}),
      .last (rr_last),
      .gnt  (pick)
   );

   // Next-state and datapath muxes. Response paths are combinational from
   // s_ready so the master sees ready in the same cycle as the memory.
   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      rr_last_nxt = rr_last;
      timed_out   = 1'b0;
      s_req       = '0;
      rsp         = '0;

      case (state)
         IDLE: begin
            if (|pick) begin
               state_nxt = BUSY;
               owner_nxt = pick[1];
            end
         end
         BUSY: begin
            s_req = own_req;
            if (s_ready) begin
               // A real response always beats a timeout in the same cycle.
               rsp.ready   = 1'b1;
               rsp.rdata   = s_rdata;
               rr_last_nxt = owner;
               state_nxt   = IDLE;
            end else if (!own_req.valid) begin
               // Master withdrew its request: abandon quietly, no turn consumed.
               state_nxt = IDLE;
            end else if (cnt == CNT_LAST) begin
               // Terminate the access ourselves; withdraw it from the memory.
               s_req.valid = 1'b0;
               rsp.ready   = 1'b1;
               rsp.rdata   = ERR_RDATA;
               timed_out   = 1'b1;
               rr_last_nxt = owner;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         rr_last    <= 1'b1;     // m0 wins the first tie after reset
         cnt        <= '0;
         err        <= 1'b0;
         err_addr   <= '0;
         err_master <= 1'b0;
      end else begin
         state   <= state_nxt;
         owner   <= owner_nxt;
         rr_last <= rr_last_nxt;
         cnt     <= (state == BUSY) ? cnt + 1'b1 : '0;

         // Only the first timeout is recorded; a timeout coinciding with a
         // clear starts a fresh record rather than being lost.
         if (timed_out && (!err || err_clr)) begin
            err        <= 1'b1;
            err_addr   <= own_req.addr;
            err_master <= owner;
         end else if (err_clr) begin
            err        <= 1'b0;
            err_addr   <= '0;
            err_master <= 1'b0;
         end
      end
   end

   assign s_valid = s_req.valid;
   assign s_instr = s_req.instr;
   assign s_addr  = s_req.addr;
   assign s_wdata = s_req.wdata;
   assign s_wstrb = s_req.wstrb;

   // rsp is only non-zero in BUSY, so routing by owner keeps the non-owner at 0.
   assign m0_ready = rsp.ready & ~owner;
   assign m0_rdata = owner ? 32'h0 : rsp.rdata;
   assign m1_ready = rsp.ready & owner;
   assign m1_rdata = owner ? rsp.rdata : 32'h0;

   assign grant = (state == BUSY) ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_picorv32_mem_arbiter
// Directed bench for the two-master memory arbiter. Requests push their
// expected read data into a per-master queue; a monitor pops and compares on
// every mX_ready. A behavioural word memory with programmable latency answers
// the shared port. Inputs change #2 after posedge, outputs are read at negedge.
// -----------------------------------------------------------------------------
module tb_picorv32_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_valid, m0_instr, m1_valid, m1_instr;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_rdata, m1_rdata;
   logic        s_valid, s_instr, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic [1:0]  grant;
   logic        err, err_master, err_clr;
   logic [31:0] err_addr;

   picorv32_mem_arbiter #(.TIMEOUT(16), .ERR_RDATA(32'hDEAD_BEEF)) dut (
      .clk(clk), .reset(reset),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
      .grant(grant), .err(err), .err_addr(err_addr), .err_master(err_master),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [31:0] q0[$];
   logic [31:0] q1[$];

   // ---------------- memory model ----------------
   logic [31:0] mem [0:255];
   logic        mem_en  = 1'b1;
   int          mem_lat = 1;
   int          mem_cnt = 0;

   initial begin
      s_ready = 1'b0;
      s_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (!s_valid) begin
            mem_cnt = 0;
            s_ready = 1'b0;
            s_rdata = '0;
         end else begin
            if (mem_en && mem_cnt >= mem_lat) begin
               s_ready = 1'b1;
               if (s_wstrb == 4'b0000) begin
                  s_rdata = mem[s_addr[9:2]];
               end else begin
                  for (int b = 0; b < 4; b++)
                     if (s_wstrb[b]) mem[s_addr[9:2]][8*b +: 8] = s_wdata[8*b +: 8];
                  s_rdata = '0;
               end
            end else begin
               s_ready = 1'b0;
               s_rdata = '0;
            end
            mem_cnt++;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input int m, input logic v, input logic ins, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws);
      if (m == 0) begin
         m0_valid = v; m0_instr = ins; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
      end else begin
         m1_valid = v; m1_instr = ins; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
      end
   endtask

   // Issue one access and hold it until ready; returns the absolute cycle of
   // the response (or -1). Valid is left high; the caller lowers it.
   task automatic access(input int m, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] exp_rd, output int served);
      drive(m, 1'b1, 1'b0, a, wd, ws);
      if (m == 0) q0.push_back(exp_rd);
      else        q1.push_back(exp_rd);
      served = -1;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if ((m == 0) ? m0_ready : m1_ready) begin
            served = cyc;
            break;
         end
      end
      if (served < 0) begin
         checks++;
         errors++;
         $display("FAIL m%0d_wait_ready: no ready within 64 cycles, addr %h", m, a);
      end
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      err_clr = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (m0_ready) begin
         if (q0.size() == 0) check("m0_unexpected_ready", 32'd1, 32'd0);
         else                check("m0_rdata", m0_rdata, q0.pop_front());
         check("m0_rsp_m1_ready", {31'b0, m1_ready}, 32'd0);
         check("m0_rsp_m1_rdata", m1_rdata, 32'd0);
      end
      if (m1_ready) begin
         if (q1.size() == 0) check("m1_unexpected_ready", 32'd1, 32'd0);
         else                check("m1_rdata", m1_rdata, q1.pop_front());
         check("m1_rsp_m0_ready", {31'b0, m0_ready}, 32'd0);
         check("m1_rsp_m0_rdata", m0_rdata, 32'd0);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int base, sv0, sv1;
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[4] = 32'h1234_5678;                                    // 0x10
      for (int i = 0; i < 4; i++) mem[16 + i] = 32'h1000_0000 + i; // 0x40..
      for (int i = 0; i < 4; i++) mem[32 + i] = 32'h2000_0000 + i; // 0x80..

      @(posedge clk);
      #2;
      do_reset();

      // Reset state
      @(negedge clk);
      check("rst_grant",    {30'b0, grant}, 32'd0);
      check("rst_s_valid",  {31'b0, s_valid}, 32'd0);
      check("rst_s_addr",   s_addr, 32'd0);
      check("rst_err",      {31'b0, err}, 32'd0);
      check("rst_err_addr", err_addr, 32'd0);
      check("rst_m_ready",  {30'b0, m1_ready, m0_ready}, 32'd0);

      // 1. m0 read of 0x10, 1-cycle memory
      tick();
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      q0.push_back(32'h1234_5678);
      @(negedge clk);
      check("t1_c0_s_valid", {31'b0, s_valid}, 32'd0);
      check("t1_c0_grant",   {30'b0, grant}, 32'd0);
      tick();
      @(negedge clk);
      check("t1_c1_s_valid",  {31'b0, s_valid}, 32'd1);
      check("t1_c1_grant",    {30'b0, grant}, 32'd1);
      check("t1_c1_s_addr",   s_addr, 32'h10);
      check("t1_c1_m0_ready", {31'b0, m0_ready}, 32'd0);
      tick();
      @(negedge clk);
      check("t1_c2_m0_ready", {31'b0, m0_ready}, 32'd1);
      check("t1_c2_grant",    {30'b0, grant}, 32'd1);
      check("t1_c2_m1_ready", {31'b0, m1_ready}, 32'd0);
      tick();
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      check("t1_c3_grant", {30'b0, grant}, 32'd0);

      // 2. both continuously valid after reset: m0, m1, m0, m1 ... period 6
      tick();
      do_reset();
      base = cyc;
      fork
         begin
            for (int i = 0; i < 3; i++) begin
               access(0, 32'h40 + 32'(4 * i), '0, 4'h0, 32'h1000_0000 + 32'(i), sv0);
               check("t2_m0_cycle", 32'(sv0 - base), 32'(2 + 6 * i));
            end
            drive(0, 1'b0, 1'b0, '0, '0, '0);
         end
         begin
            for (int i = 0; i < 3; i++) begin
               access(1, 32'h80 + 32'(4 * i), '0, 4'h0, 32'h2000_0000 + 32'(i), sv1);
               check("t2_m1_cycle", 32'(sv1 - base), 32'(5 + 6 * i));
            end
            drive(1, 1'b0, 1'b0, '0, '0, '0);
         end
      join

      // 3. m1 alone, back-to-back, right after m1 was served last
      tick();
      base = cyc;
      for (int i = 0; i < 3; i++) begin
         access(1, 32'h80 + 32'(4 * i), '0, 4'h0, 32'h2000_0000 + 32'(i), sv1);
         check("t3_m1_cycle", 32'(sv1 - base), 32'(2 + 3 * i));
      end
      drive(1, 1'b0, 1'b0, '0, '0, '0);

      // 4. timeout: memory never answers
      tick();
      mem_en = 1'b0;
      drive(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
      q0.push_back(32'hDEAD_BEEF);
      for (int k = 1; k <= 16; k++) begin
         tick();
         @(negedge clk);
         if (k == 15) check("t4_c15_s_valid", {31'b0, s_valid}, 32'd1);
         if (k == 16) begin
            check("t4_c16_s_valid", {31'b0, s_valid}, 32'd0);
            check("t4_c16_m0_ready", {31'b0, m0_ready}, 32'd1);
            check("t4_c16_err_before", {31'b0, err}, 32'd0);
         end
      end
      tick();
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      check("t4_err",        {31'b0, err}, 32'd1);
      check("t4_err_addr",   err_addr, 32'h400);
      check("t4_err_master", {31'b0, err_master}, 32'd0);
      check("t4_grant_idle", {30'b0, grant}, 32'd0);
      // second timeout from m1 must not overwrite the record
      tick();
      base = cyc;
      access(1, 32'h800, '0, 4'h0, 32'hDEAD_BEEF, sv1);
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      check("t4_2nd_cycle", 32'(sv1 - base), 32'd16);
      @(negedge clk);
      check("t4_2nd_err",        {31'b0, err}, 32'd1);
      check("t4_2nd_err_addr",   err_addr, 32'h400);
      check("t4_2nd_err_master", {31'b0, err_master}, 32'd0);
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      @(negedge clk);
      check("t4_clr_err",        {31'b0, err}, 32'd0);
      check("t4_clr_err_addr",   err_addr, 32'd0);
      check("t4_clr_err_master", {31'b0, err_master}, 32'd0);
      mem_en = 1'b1;

      // 5. m1 write with partial strobes, then read it back through m0
      tick();
      drive(1, 1'b1, 1'b1, 32'h20, 32'hA5A5_0F0F, 4'b0101);
      q1.push_back(32'h0);
      tick();
      @(negedge clk);
      check("t5_s_valid", {31'b0, s_valid}, 32'd1);
      check("t5_s_instr", {31'b0, s_instr}, 32'd1);
      check("t5_s_addr",  s_addr, 32'h20);
      check("t5_s_wdata", s_wdata, 32'hA5A5_0F0F);
      check("t5_s_wstrb", {28'b0, s_wstrb}, 32'h5);
      check("t5_grant",   {30'b0, grant}, 32'd2);
      tick();
      @(negedge clk);
      check("t5_m1_ready", {31'b0, m1_ready}, 32'd1);
      check("t5_m0_rdata", m0_rdata, 32'd0);
      tick();
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      base = cyc;
      access(0, 32'h20, '0, 4'h0, 32'h00A5_000F, sv0);
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      check("t5_rb_cycle", 32'(sv0 - base), 32'd2);

      // 6. reset during BUSY cycle 2, with an error recorded beforehand
      tick();
      mem_en = 1'b0;
      access(0, 32'h404, '0, 4'h0, 32'hDEAD_BEEF, sv0);
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      mem_en = 1'b1;
      @(negedge clk);
      check("t6_err_set", {31'b0, err}, 32'd1);
      tick();
      mem_lat = 5;
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);   // never answered
      tick();
      tick();
      reset = 1'b1;
      @(negedge clk);
      check("t6_busy2_grant", {30'b0, grant}, 32'd1);
      tick();
      reset = 1'b0;
      drive(0, 1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      check("t6_grant",   {30'b0, grant}, 32'd0);
      check("t6_s_valid", {31'b0, s_valid}, 32'd0);
      check("t6_err",     {31'b0, err}, 32'd0);
      check("t6_m0_ready", {31'b0, m0_ready}, 32'd0);
      mem_lat = 1;
      tick();
      base = cyc;
      access(1, 32'h10, '0, 4'h0, 32'h1234_5678, sv1);
      drive(1, 1'b0, 1'b0, '0, '0, '0);
      check("t6_fresh_cycle", 32'(sv1 - base), 32'd2);

      tick();
      tick();
      check("q0_drained", 32'(q0.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
